// File: rtl/avmm_bridge_pkg.sv
// Register map and bit positions shared by the Avalon-MM stream bridge.
// Contents: word addresses of the four registers, STATUS field positions,
// CTRL bit positions and a helper that assembles the 32-bit STATUS word.
package avmm_bridge_pkg;

    localparam int unsigned ADDR_DATA       = 0;
    localparam int unsigned ADDR_CTRL       = 1;
    localparam int unsigned ADDR_STATUS     = 2;
    localparam int unsigned ADDR_STATUS_CLR = 3;

    localparam int unsigned ST_IN_LVL_LSB  = 0;
    localparam int unsigned ST_OUT_LVL_LSB = 8;
    localparam int unsigned ST_IN_FULL     = 16;
    localparam int unsigned ST_OUT_EMPTY   = 17;
    localparam int unsigned ST_OVF         = 18;
    localparam int unsigned ST_UNF         = 19;
    localparam int unsigned ST_BUSY        = 20;

    localparam int unsigned CTRL_SOFT_CLR = 0;
    localparam int unsigned CTRL_IRQ_EN   = 1;

    function automatic logic [31:0] pack_status(
        input logic [7:0] in_lvl,
        input logic [7:0] out_lvl,
        input logic       in_full,
        input logic       out_empty,
        input logic       ovf,
        input logic       unf,
        input logic       busy
    );
        logic [31:0] s;
        s                          = '0;
        s[ST_IN_LVL_LSB +: 8]      = in_lvl;
        s[ST_OUT_LVL_LSB +: 8]     = out_lvl;
        s[ST_IN_FULL]              = in_full;
        s[ST_OUT_EMPTY]            = out_empty;
        s[ST_OVF]                  = ovf;
        s[ST_UNF]                  = unf;
        s[ST_BUSY]                 = busy;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush.
// Ports: clk, reset_n (async, active-low), clear (flush), push/din,
// pop/dout (dout shows the head, valid while !empty), full, empty, level.
// Push while full is accepted only together with a pop; pop while empty is
// ignored, so an empty FIFO never passes data through in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            if (do_push && !do_pop)
                level <= level + 1'b1;
            else if (!do_push && do_pop)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/avmm_stream_bridge.sv
// Avalon-MM slave front-end feeding a streaming compute core.
// Host side: address/read/write/writedata/readdata (latency 1)/waitrequest,
// irq (level). Core side: op_data/op_valid/op_ready towards the core,
// res_data/res_valid back from it (no back-pressure on results).
// Operands queue in an input FIFO, results in an output FIFO; issue is
// limited by a credit check so every in-flight result has a free slot.
module avmm_stream_bridge
    import avmm_bridge_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 2,
    parameter int unsigned IN_DEPTH     = 8,
    parameter int unsigned OUT_DEPTH    = 8,
    parameter int unsigned WAIT_ON_FULL = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              waitrequest,
    output logic              irq,
    output logic [DATA_W-1:0] op_data,
    output logic              op_valid,
    input  logic              op_ready,
    input  logic [DATA_W-1:0] res_data,
    input  logic              res_valid
);

    localparam int unsigned ILW = $clog2(IN_DEPTH) + 1;
    localparam int unsigned OLW = $clog2(OUT_DEPTH) + 1;
    localparam int unsigned CW  = OLW + 1;

    logic              sel_data, sel_ctrl, sel_status, sel_sclr;
    logic              wr_data, rd_data, soft_clr;
    logic              in_push, in_drop, in_full, in_empty;
    logic [ILW-1:0]    in_level;
    logic              out_push, out_pop, out_full, out_empty;
    logic [OLW-1:0]    out_level;
    logic [DATA_W-1:0] out_dout;
    logic              issue, res_ok, res_err, res_keep;
    logic [OLW-1:0]    inflight, inflight_nxt, discard;
    logic [CW-1:0]     credit_used;
    logic              ovf, unf, irq_en;
    logic [31:0]       status_word;
    logic              unused_sig;

    assign sel_data   = (address == ADDR_W'(ADDR_DATA));
    assign sel_ctrl   = (address == ADDR_W'(ADDR_CTRL));
    assign sel_status = (address == ADDR_W'(ADDR_STATUS));
    assign sel_sclr   = (address == ADDR_W'(ADDR_STATUS_CLR));

    assign wr_data  = write && sel_data;
    assign rd_data  = read && sel_data;
    assign soft_clr = write && sel_ctrl && writedata[CTRL_SOFT_CLR];

    assign waitrequest = (WAIT_ON_FULL != 0) && wr_data && in_full;
    assign in_push     = wr_data && !in_full && !soft_clr;
    assign in_drop     = (WAIT_ON_FULL == 0) && wr_data && in_full;

    assign credit_used = CW'(inflight) + CW'(out_level);
    assign op_valid    = !in_empty && (credit_used < CW'(OUT_DEPTH));
    assign issue       = op_valid && op_ready;

    assign res_ok   = res_valid && (inflight != '0);
    assign res_err  = res_valid && (inflight == '0);
    assign res_keep = res_ok && (discard == '0);
    assign out_push = res_keep;
    assign out_pop  = rd_data && !out_empty;

    assign status_word = pack_status(8'(in_level), 8'(out_level), in_full, out_empty,
                                     ovf, unf, (inflight != '0));

    assign unused_sig = ^{writedata, out_full};

    always_comb begin
        inflight_nxt = inflight;
        if (issue && !res_ok)
            inflight_nxt = inflight + 1'b1;
        else if (!issue && res_ok)
            inflight_nxt = inflight - 1'b1;
    end

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (soft_clr),
        .push    (in_push),
        .pop     (issue),
        .din     (writedata),
        .dout    (op_data),
        .full    (in_full),
        .empty   (in_empty),
        .level   (in_level)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (soft_clr),
        .push    (out_push),
        .pop     (out_pop),
        .din     (res_data),
        .dout    (out_dout),
        .full    (out_full),
        .empty   (out_empty),
        .level   (out_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
            discard  <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            irq_en   <= 1'b0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            inflight <= inflight_nxt;

            // Discard loads the post-edge in-flight count: an operand issued
            // on the clear edge is covered, and a result landing on it is
            // already lost to the flush so it must not be counted again.
            if (soft_clr)
                discard <= inflight_nxt;
            else if (res_ok && (discard != '0))
                discard <= discard - 1'b1;

            if (soft_clr) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end else if (write && sel_sclr) begin
                if (writedata[ST_OVF]) ovf <= 1'b0;
                if (writedata[ST_UNF]) unf <= 1'b0;
            end
            if (in_drop || res_err)     ovf <= 1'b1;
            if (rd_data && out_empty)   unf <= 1'b1;

            if (write && sel_ctrl)
                irq_en <= writedata[CTRL_IRQ_EN];
            irq <= irq_en && !out_empty;

            if (read) begin
                if (sel_data)
                    readdata <= out_empty ? '0 : out_dout;
                else if (sel_ctrl)
                    readdata <= DATA_W'({irq_en, 1'b0});
                else if (sel_status || sel_sclr)
                    readdata <= DATA_W'(status_word);
                else
                    readdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_avmm_stream_bridge.sv
module tb_avmm_stream_bridge;
    import avmm_bridge_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 2;
    localparam int unsigned OD = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    // Main instance: stalls on full
    logic [AW-1:0] address;
    logic          read, write;
    logic [DW-1:0] writedata, readdata;
    logic          waitrequest, irq;
    logic [DW-1:0] op_data, res_data;
    logic          op_valid, op_ready, res_valid;

    // Second instance: drops on full
    logic [AW-1:0] b_address;
    logic          b_read, b_write;
    logic [DW-1:0] b_writedata, b_readdata;
    logic          b_waitrequest, b_irq;
    logic [DW-1:0] b_op_data, b_res_data;
    logic          b_op_valid, b_op_ready, b_res_valid;

    avmm_stream_bridge #(.DATA_W(DW), .ADDR_W(AW), .IN_DEPTH(8), .OUT_DEPTH(OD),
                         .WAIT_ON_FULL(1)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest), .irq(irq),
        .op_data(op_data), .op_valid(op_valid), .op_ready(op_ready),
        .res_data(res_data), .res_valid(res_valid));

    avmm_stream_bridge #(.DATA_W(DW), .ADDR_W(AW), .IN_DEPTH(8), .OUT_DEPTH(OD),
                         .WAIT_ON_FULL(0)) dut_drop (
        .clk(clk), .reset_n(reset_n), .address(b_address), .read(b_read), .write(b_write),
        .writedata(b_writedata), .readdata(b_readdata), .waitrequest(b_waitrequest),
        .irq(b_irq), .op_data(b_op_data), .op_valid(b_op_valid), .op_ready(b_op_ready),
        .res_data(b_res_data), .res_valid(b_res_valid));

    // Loopback core, 3-cycle latency, result equals operand
    logic [DW-1:0] pd0, pd1, pd2;
    logic [2:0]    pv;
    logic          inj_res;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pv <= '0;
            pd0 <= '0; pd1 <= '0; pd2 <= '0;
        end else begin
            pv  <= {pv[1:0], op_valid && op_ready};
            pd0 <= op_data;
            pd1 <= pd0;
            pd2 <= pd1;
        end
    end
    assign res_valid = pv[2] | inj_res;
    assign res_data  = pd2;

    int unsigned passed = 0;
    int unsigned total  = 0;

    // Reference model: accepted operands not yet read, sticky flags
    logic [DW-1:0] pend[$];
    bit ovf_m, unf_m, irq_en_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_status(input int unsigned in_l, input int unsigned out_l);
        return {11'b0, 1'b0, unf_m, ovf_m, (out_l == 0), (in_l == 8), 8'(out_l), 8'(in_l)};
    endfunction

    task automatic settle();
        repeat (10) @(negedge clk);
    endtask

    task automatic a_write(input int unsigned a, input logic [DW-1:0] d);
        int unsigned n;
        @(negedge clk);
        address = AW'(a); writedata = d; write = 1'b1;
        n = 0;
        while (waitrequest && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (waitrequest) chk("write_timeout", 32'(waitrequest), 0);
        @(posedge clk);
        #1 write = 1'b0;
    endtask

    task automatic a_read(input int unsigned a, output logic [DW-1:0] d);
        @(negedge clk);
        address = AW'(a); read = 1'b1;
        @(posedge clk);
        #1 read = 1'b0;
        d = readdata;
    endtask

    task automatic b_wr(input int unsigned a, input logic [DW-1:0] d);
        @(negedge clk);
        b_address = AW'(a); b_writedata = d; b_write = 1'b1;
        #1 chk("drop_no_stall", 32'(b_waitrequest), 0);
        @(posedge clk);
        #1 b_write = 1'b0;
    endtask

    task automatic b_rd(input int unsigned a, output logic [DW-1:0] d);
        @(negedge clk);
        b_address = AW'(a); b_read = 1'b1;
        @(posedge clk);
        #1 b_read = 1'b0;
        d = b_readdata;
    endtask

    task automatic push_op(input logic [DW-1:0] v);
        a_write(ADDR_DATA, v);
        pend.push_back(v);
    endtask

    task automatic status_chk(input string tag, input int unsigned in_l, input int unsigned out_l);
        logic [DW-1:0] rd;
        a_read(ADDR_STATUS, rd);
        chk(tag, rd, exp_status(in_l, out_l));
    endtask

    // Core ready and idle long enough: results fill the output FIFO up to its depth
    task automatic settled_status_chk(input string tag);
        int unsigned n, o;
        settle();
        n = pend.size();
        o = (n > OD) ? OD : n;
        status_chk(tag, n - o, o);
    endtask

    task automatic read_data_chk(input string tag);
        logic [DW-1:0] rd, exp;
        settle();
        a_read(ADDR_DATA, rd);
        if (pend.size() > 0) exp = pend.pop_front();
        else begin
            exp = '0;
            unf_m = 1'b1;
        end
        chk(tag, rd, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd, v;
        int unsigned n;
        logic [DW-1:0] first_b;

        reset_n = 1'b1;
        address = '0; read = 1'b0; write = 1'b0; writedata = '0;
        op_ready = 1'b0; inj_res = 1'b0;
        b_address = '0; b_read = 1'b0; b_write = 1'b0; b_writedata = '0;
        b_op_ready = 1'b0; b_res_valid = 1'b0; b_res_data = '0;
        ovf_m = 0; unf_m = 0; irq_en_m = 0;

        #2 reset_n = 1'b0;
        #1;
        chk("rst_readdata", readdata, 0);
        chk("rst_waitrequest", 32'(waitrequest), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_op_valid", 32'(op_valid), 0);
        chk("rst_b_irq", 32'(b_irq), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        status_chk("rst_status", 0, 0);

        // Loopback with the three reference operands
        op_ready = 1'b1;
        push_op(32'h437f0000);
        push_op(32'h43000000);
        push_op(32'h42080000);
        settled_status_chk("t1_status_full");
        for (int i = 0; i < 3; i++) read_data_chk("t1_data");
        settled_status_chk("t1_status_idle");

        // Random loopback
        for (int i = 0; i < 5; i++) push_op($urandom);
        for (int i = 0; i < 5; i++) read_data_chk("rand_data");

        // Credit limit: 12 operands, host not reading
        for (int i = 0; i < 12; i++) push_op($urandom);
        settle();
        chk("t4_op_valid_blocked", 32'(op_valid), 0);
        settled_status_chk("t4_status");
        for (int i = 0; i < 12; i++) read_data_chk("t4_data");
        settled_status_chk("t4_status_idle");

        // Stall on full input FIFO
        op_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_op($urandom);
        settle();
        status_chk("t2_status_full", 8, 0);
        chk("t2_op_data_head", op_data, pend[0]);
        v = $urandom;
        @(negedge clk);
        address = AW'(ADDR_DATA); writedata = v; write = 1'b1;
        #1 chk("t2_stall_now", 32'(waitrequest), 1);
        repeat (3) begin
            @(negedge clk);
            chk("t2_stall_hold", 32'(waitrequest), 1);
        end
        op_ready = 1'b1;
        n = 0;
        while (waitrequest && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t2_released", 32'(waitrequest), 0);
        @(posedge clk);
        #1 write = 1'b0;
        pend.push_back(v);
        settled_status_chk("t2_status_after");
        for (int i = 0; i < 9; i++) read_data_chk("t2_data");
        settled_status_chk("t2_status_idle");

        // Drop on full input FIFO (second instance, core never ready)
        for (int i = 0; i < 9; i++) begin
            v = $urandom;
            if (i == 0) first_b = v;
            b_wr(ADDR_DATA, v);
        end
        chk("t3_op_valid", 32'(b_op_valid), 1);
        chk("t3_op_data_head", b_op_data, first_b);
        b_rd(ADDR_STATUS, rd);
        chk("t3_status_ovf", rd, 32'h0007_0008);
        b_wr(ADDR_STATUS_CLR, 32'h0004_0000);
        b_rd(ADDR_STATUS_CLR, rd);
        chk("t3_status_cleared", rd, 32'h0003_0008);
        chk("t3_irq", 32'(b_irq), 0);

        // Underflow read and interrupt
        read_data_chk("t5_empty_read");
        status_chk("t5_unf", 0, 0);
        a_write(ADDR_CTRL, 32'h2);
        irq_en_m = 1'b1;
        a_read(ADDR_CTRL, rd);
        chk("t5_ctrl", rd, {30'b0, irq_en_m, 1'b0});
        a_write(ADDR_STATUS_CLR, 32'h0008_0000);
        unf_m = 1'b0;
        status_chk("t5_unf_cleared", 0, 0);
        push_op(32'h42be0000);
        chk("t5_irq_before_result", 32'(irq), 0);
        settle();
        chk("t5_irq_set", 32'(irq), 1);
        read_data_chk("t5_data");
        settle();
        chk("t5_irq_clear", 32'(irq), 0);

        // Result with nothing in flight is a protocol error
        @(negedge clk); inj_res = 1'b1;
        @(negedge clk); inj_res = 1'b0;
        ovf_m = 1'b1;
        settled_status_chk("proto_err_ovf");
        a_write(ADDR_STATUS_CLR, 32'h0004_0000);
        ovf_m = 1'b0;
        status_chk("proto_err_cleared", 0, 0);

        // Soft clear with three operands in flight
        for (int i = 0; i < 3; i++) a_write(ADDR_DATA, $urandom);
        a_write(ADDR_CTRL, 32'h3);
        a_read(ADDR_STATUS, rd);
        chk("t6_flushed_busy", rd, exp_status(0, 0) | 32'h0010_0000);
        settle();
        chk("t6_irq_quiet", 32'(irq), 0);
        settled_status_chk("t6_all_dropped");
        push_op(32'h42f40000);
        settled_status_chk("t6_one_result");
        read_data_chk("t6_data");

        // Reset in the middle of traffic
        push_op($urandom);
        push_op($urandom);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_op_valid", 32'(op_valid), 0);
        chk("mid_rst_readdata", readdata, 0);
        chk("mid_rst_irq", 32'(irq), 0);
        @(negedge clk);
        reset_n = 1'b1;
        pend.delete();
        ovf_m = 0; unf_m = 0; irq_en_m = 0;
        settled_status_chk("mid_rst_status");
        a_read(ADDR_CTRL, rd);
        chk("mid_rst_ctrl", rd, 0);
        read_data_chk("mid_rst_empty_read");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/avmm_stream_bridge.md
Name: avmm_stream_bridge

Overview:
- Parametrised Avalon-MM slave front-end for the CORDIC accelerators, successor to the single-register `top` wrapper.
- Host writes IEEE-754 float32 operands into an input FIFO. The block streams them to a compute core over a valid/ready interface, captures the core's results in an output FIFO, and exposes status, sticky error flags and an interrupt.
- A credit counter guarantees that no core result is ever lost.

Parameters:
- DATA_W, 32: operand/result width.
- ADDR_W, 2: Avalon word-address width. Only addresses 0–3 are decoded; higher addresses read 0 and writes are ignored.
- IN_DEPTH, 8: input FIFO entries. Range 2–255.
- OUT_DEPTH, 8: output FIFO entries. Range 2–255. Also the maximum number of operands in flight.
- WAIT_ON_FULL, 1: input-full policy. 1 = stall the host with waitrequest. 0 = drop the write and set OVF.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset. Asynchronous assert, active-low.
- address  in  ADDR_W  word address.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- writedata  in  DATA_W  write data.
- readdata  out  DATA_W  read data, registered, fixed read latency 1.
- waitrequest  out  1  write stall (only when WAIT_ON_FULL=1).
- irq  out  1  level interrupt.
- op_data  out  DATA_W  operand to core.
- op_valid  out  1  operand valid.
- op_ready  in  1  core accepts operand.
- res_data  in  DATA_W  result from core.
- res_valid  in  1  result strobe. The core cannot be back-pressured.

Behaviour:
- Clock and reset: single clock domain `clk`; reset is asynchronous, active-low (`reset_n`).
- Reset values: readdata=0, waitrequest=0, irq=0, op_valid=0; both FIFOs empty; inflight=0, discard=0, OVF=0, UNF=0, IRQ_EN=0.
- Register map:
  - 0 DATA: write pushes writedata to the input FIFO. Read pops the output FIFO head.
  - 1 CTRL:
    - Write bit0=1: soft clear (self-clearing).
    - Write bit1: IRQ_EN.
    - Read: {30'b0, IRQ_EN, 1'b0}.
  - 2 STATUS, read-only:
    - [7:0] input level; [15:8] output level.
    - bit16 in_full; bit17 out_empty; bit18 OVF; bit19 UNF; bit20 busy (inflight≠0).
  - 3 STATUS_CLR: write 1s to bits 18/19 to clear OVF/UNF. Reads as STATUS.
- DATA write with input FIFO full:
  - WAIT_ON_FULL=1: waitrequest=1 combinationally while write&address==0&in_full. The write completes on the first cycle a slot frees.
  - WAIT_ON_FULL=0: no stall, data dropped, OVF<=1.
- DATA read with output FIFO empty: readdata=0 next cycle, UNF<=1, no pop. Otherwise readdata=head next cycle and pop.
- Operand issue:
  - op_valid = !in_empty && (inflight + out_level) < OUT_DEPTH. op_data = input FIFO head.
  - Pop and inflight+1 on op_valid&op_ready.
- Result capture:
  - On res_valid: inflight-1.
  - If discard≠0: discard-1 and the result is dropped.
  - Else: push to the output FIFO.
  - res_valid with inflight=0 is a protocol error: set OVF, ignore.
- Simultaneous issue and result in the same cycle: inflight unchanged.
- FIFO rules:
  - Push and pop in the same cycle are allowed when full (level constant) and when non-empty.
  - When empty, push only; no same-cycle pass-through.
  - Pointers wrap modulo DEPTH. Level width is clog2(DEPTH)+1.
- Soft clear:
  - Flushes both FIFOs next cycle and clears OVF/UNF.
  - discard <= inflight. inflight keeps counting down as results arrive.
  - A host push in the same cycle as the clear is discarded.
- irq = IRQ_EN & !out_empty, registered (1-cycle lag).
- Reset mid-operation: everything returns to reset values immediately. The core is expected to share reset_n.

Decomposition:
- Package avmm_bridge_pkg holds:
  - register address constants ADDR_DATA/CTRL/STATUS/STATUS_CLR;
  - status bit indices;
  - CTRL bit indices.
- Sub-module sync_fifo (params WIDTH, DEPTH; ports push/pop/din/dout/full/empty/level), instantiated twice.
- Register decode, credit logic and discard counter live in the top.

Test Plan:
1. Loopback core with 3-cycle latency, result = operand. Write 0x437f0000, 0x43000000, 0x42080000 to DATA → three reads return the same values in order; STATUS busy=0 and out_empty=1 afterwards.
2. WAIT_ON_FULL=1, op_ready held 0. Write 9 operands (IN_DEPTH=8) → 9th write sees waitrequest=1 until op_ready=1 pops one; no OVF.
3. WAIT_ON_FULL=0, same stimulus → 9th write completes with no stall; STATUS bit18=1; write 0x40000 to addr 3 → bit18=0.
4. Core always ready, host never reads. Push 12 operands, OUT_DEPTH=8 → op_valid drops once inflight+out_level=8; output level stays 8; no result lost; remaining 4 issue as reads drain.
5. Read DATA with output FIFO empty → readdata=0 and UNF=1. Set IRQ_EN, push 0x42be0000 → irq=1 after result arrives; irq=0 after readout.
6. Soft clear with 3 in flight → both levels 0, discard=3; the next 3 results are dropped; a subsequent 0x42f40000 round-trips correctly.
